// File: rtl/comb_resp_checker_pkg.sv
// Shared constants and helpers for the combinational response checker.
// FSM encodings are plain localparams so older tools and wrappers can reuse them.
package comb_resp_checker_pkg;

  localparam int unsigned DefVecW      = 5;
  localparam int unsigned DefCntW      = 16;
  localparam int unsigned DefSettleCyc = 2;

  // Expected y is 1 only for vectors 0 and 31 (all-zero / all-one inputs).
  localparam logic [31:0] DefTruth = 32'h8000_0001;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StSettle = 2'd1;
  localparam state_t StSample = 2'd2;

  // Bits needed to hold max_val; never returns zero so a 0-cycle settle still elaborates.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/comb_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter
  import comb_resp_checker_pkg::*;
#(
  parameter int unsigned W = DefCntW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/comb_resp_checker.sv
// Drives accepted vectors onto a combinational function, waits SETTLE_CYC cycles, then
// compares its output with TRUTH and keeps saturating pass/fail counts plus first failure.
module comb_resp_checker
  import comb_resp_checker_pkg::*;
#(
  parameter int unsigned           VEC_W      = DefVecW,
  parameter int unsigned           SETTLE_CYC = DefSettleCyc,
  parameter int unsigned           CNT_W      = DefCntW,
  parameter logic [2**VEC_W-1:0]   TRUTH      = DefTruth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_valid,
  input  logic [VEC_W-1:0] vec,
  output logic             vec_ready,
  output logic [VEC_W-1:0] vec_out,
  input  logic             dut_y,
  input  logic             clear,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam int unsigned    SetW       = cnt_width(SETTLE_CYC);
  localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYC);
  localparam logic [SetW-1:0] SettleLast = SetW'(1);

  state_t           state_q, state_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             ffv_q, ffv_d;
  logic [VEC_W-1:0] ffvec_q, ffvec_d;

  logic accept;
  logic sampling;
  logic exp_y;
  logic pass_inc;
  logic fail_inc;

  assign vec_ready = (state_q == StIdle);
  assign busy      = ~vec_ready;
  assign accept    = vec_valid & vec_ready;
  assign sampling  = (state_q == StSample);
  assign exp_y     = TRUTH[vec_q];
  assign pass_inc  = sampling & (dut_y == exp_y);
  assign fail_inc  = sampling & (dut_y != exp_y);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          vec_d    = vec;
          settle_d = SettleLoad;
          state_d  = (SETTLE_CYC > 0) ? StSettle : StSample;
        end
      end
      StSettle: begin
        settle_d = settle_q - 1'b1;
        if (settle_q == SettleLast) begin
          state_d = StSample;
        end
      end
      StSample: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Clear beats a same-edge failure, so the discarded result cannot be captured either.
  always_comb begin
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    if (clear) begin
      ffv_d   = 1'b0;
      ffvec_d = '0;
    end else if (fail_inc && !ffv_q) begin
      ffv_d   = 1'b1;
      ffvec_d = vec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      vec_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pass_inc),
    .clr   (clear),
    .cnt   (pass_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_inc),
    .clr   (clear),
    .cnt   (fail_cnt)
  );

  assign vec_out        = vec_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;

endmodule

// File: tb/tb_comb_resp_checker.sv
// Bench for comb_resp_checker: a default build (settle 2, 16-bit counts) and a settle-0,
// 2-bit-count build, each compared every cycle against a transaction-level model.
module tb_comb_resp_checker;

  typedef struct {
    bit         pend;
    int         left;
    logic [4:0] vec;
    int         pass;
    int         fail;
    bit         ffv;
    logic [4:0] ffvec;
    bit         acc;
  } model_t;

  logic clk;
  logic rst_n;

  logic       a_valid, a_y, a_clr, a_ready, a_busy, a_ffv;
  logic [4:0] a_vec, a_vec_out, a_ffvec;
  logic [15:0] a_pass, a_fail;

  logic       b_valid, b_y, b_clr, b_ready, b_busy, b_ffv;
  logic [4:0] b_vec, b_vec_out, b_ffvec;
  logic [1:0] b_pass, b_fail;

  model_t ma, mb;
  int     cyc = 0;
  int     acc_cyc = 0;
  int     nchecks = 0;
  int     nerr = 0;
  bit     chk_en = 0;

  comb_resp_checker u_dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .vec_valid      (a_valid),
    .vec            (a_vec),
    .vec_ready      (a_ready),
    .vec_out        (a_vec_out),
    .dut_y          (a_y),
    .clear          (a_clr),
    .busy           (a_busy),
    .pass_cnt       (a_pass),
    .fail_cnt       (a_fail),
    .first_fail_vld (a_ffv),
    .first_fail_vec (a_ffvec)
  );

  comb_resp_checker #(
    .SETTLE_CYC (0),
    .CNT_W      (2)
  ) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .vec_valid      (b_valid),
    .vec            (b_vec),
    .vec_ready      (b_ready),
    .vec_out        (b_vec_out),
    .dut_y          (b_y),
    .clear          (b_clr),
    .busy           (b_busy),
    .pass_cnt       (b_pass),
    .fail_cnt       (b_fail),
    .first_fail_vld (b_ffv),
    .first_fail_vec (b_ffvec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The checked function is y = (a & b & c & d & e) | ~(a | b | c | d | e).
  function automatic bit exp_y(input logic [4:0] v);
    return (v == 5'd0) || (v == 5'd31);
  endfunction

  function automatic model_t model_rst();
    model_t m;
    m.pend = 0; m.left = 0; m.vec = '0; m.pass = 0; m.fail = 0;
    m.ffv = 0; m.ffvec = '0; m.acc = 0;
    return m;
  endfunction

  // One clock edge: a vector accepted at edge k resolves at edge k+settle+1.
  function automatic model_t step(input model_t m, input int settle, input int maxc,
                                  input bit valid, input logic [4:0] v, input bit y,
                                  input bit clr);
    model_t n = m;
    n.acc = 0;
    if (m.pend) begin
      n.left = m.left - 1;
      if (n.left == 0) begin
        n.pend = 0;
        if (y == exp_y(m.vec)) begin
          if (n.pass < maxc) n.pass = n.pass + 1;
        end else begin
          if (n.fail < maxc) n.fail = n.fail + 1;
          if (!n.ffv) begin
            n.ffv   = 1;
            n.ffvec = m.vec;
          end
        end
      end
    end else if (valid) begin
      n.pend = 1;
      n.left = settle + 1;
      n.vec  = v;
      n.acc  = 1;
    end
    if (clr) begin
      n.pass = 0; n.fail = 0; n.ffv = 0; n.ffvec = '0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= model_rst();
      mb <= model_rst();
    end else begin
      ma <= step(ma, 2, 65535, a_valid, a_vec, a_y, a_clr);
      mb <= step(mb, 0, 3, b_valid, b_vec, b_y, b_clr);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_ready", 32'(a_ready), 32'(!ma.pend));
      check("a_busy", 32'(a_busy), 32'(ma.pend));
      check("a_vec_out", 32'(a_vec_out), 32'(ma.vec));
      check("a_pass", 32'(a_pass), ma.pass);
      check("a_fail", 32'(a_fail), ma.fail);
      check("a_ffv", 32'(a_ffv), 32'(ma.ffv));
      check("a_ffvec", 32'(a_ffvec), 32'(ma.ffvec));
      check("b_ready", 32'(b_ready), 32'(!mb.pend));
      check("b_vec_out", 32'(b_vec_out), 32'(mb.vec));
      check("b_pass", 32'(b_pass), mb.pass);
      check("b_fail", 32'(b_fail), mb.fail);
      check("b_ffv", 32'(b_ffv), 32'(mb.ffv));
      check("b_ffvec", 32'(b_ffvec), 32'(mb.ffvec));
    end
  end

  task automatic nexte();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_a(input logic [4:0] v, input bit y);
    bit got = 0;
    a_valid = 1'b1; a_vec = v; a_y = y;
    for (int i = 0; i < 40 && !got; i++) begin
      nexte();
      got = ma.acc;
    end
    a_valid = 1'b0;
    if (got) acc_cyc = cyc;
    else check("a_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic offer_b(input logic [4:0] v, input bit y);
    bit got = 0;
    b_valid = 1'b1; b_vec = v; b_y = y;
    for (int i = 0; i < 40 && !got; i++) begin
      nexte();
      got = mb.acc;
    end
    b_valid = 1'b0;
    if (!got) check("b_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 40 && ma.pend; i++) nexte();
    if (ma.pend) check("a_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c1;
    rst_n = 1'b0;
    a_valid = 0; a_vec = '0; a_y = 0; a_clr = 0;
    b_valid = 0; b_vec = '0; b_y = 0; b_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    nexte();
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_vec_out", 32'(a_vec_out), 32'd0);
    check("rst_pass", 32'(a_pass), 32'd0);

    // First vector: result lands three edges after acceptance.
    offer_a(5'd0, 1'b1);
    check("lat_busy", 32'(a_busy), 32'd1);
    nexte(); nexte();
    check("lat_pass_early", 32'(a_pass), 32'd0);
    nexte();
    check("lat_pass", 32'(a_pass), 32'd1);
    check("lat_ready", 32'(a_ready), 32'd1);
    check("lat_fail", 32'(a_fail), 32'd0);

    offer_a(5'd1, 1'b1);
    wait_idle_a();
    check("ff1_fail", 32'(a_fail), 32'd1);
    check("ff1_vld", 32'(a_ffv), 32'd1);
    check("ff1_vec", 32'(a_ffvec), 32'd1);
    offer_a(5'd2, 1'b1);
    wait_idle_a();
    check("ff2_fail", 32'(a_fail), 32'd2);
    check("ff2_vec", 32'(a_ffvec), 32'd1);

    a_clr = 1'b1; nexte(); a_clr = 1'b0;
    check("clr_pass", 32'(a_pass), 32'd0);
    check("clr_ffv", 32'(a_ffv), 32'd0);

    // Back-to-back with valid held: one vector per SETTLE_CYC+2 cycles.
    offer_a(5'd0, 1'b1);
    c1 = acc_cyc;
    offer_a(5'd31, 1'b1);
    check("b2b_gap", 32'(acc_cyc - c1), 32'd4);
    wait_idle_a();
    check("b2b_pass", 32'(a_pass), 32'd2);

    offer_a(5'd4, 1'b1);
    wait_idle_a();
    check("pre_clr_ffvec", 32'(a_ffvec), 32'd4);
    offer_a(5'd5, 1'b1);
    nexte(); nexte();
    a_clr = 1'b1; nexte(); a_clr = 1'b0;
    check("clrs_fail", 32'(a_fail), 32'd0);
    check("clrs_ffv", 32'(a_ffv), 32'd0);
    check("clrs_ready", 32'(a_ready), 32'd1);

    offer_a(5'd31, 1'b1);
    wait_idle_a();
    offer_a(5'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(a_ready), 32'd1);
    check("arst_busy", 32'(a_busy), 32'd0);
    check("arst_vec_out", 32'(a_vec_out), 32'd0);
    check("arst_pass", 32'(a_pass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nexte();
    offer_a(5'd31, 1'b1);
    wait_idle_a();
    check("post_rst_pass", 32'(a_pass), 32'd1);

    // Zero-settle, 2-bit counter build.
    offer_b(5'd31, 1'b1);
    check("s0_pass_early", 32'(b_pass), 32'd0);
    nexte();
    check("s0_pass", 32'(b_pass), 32'd1);
    check("s0_ready", 32'(b_ready), 32'd1);
    repeat (4) begin
      offer_b(5'd31, 1'b1);
      nexte();
    end
    check("sat_pass", 32'(b_pass), 32'd3);
    offer_b(5'd3, 1'b1);
    nexte();
    repeat (4) begin
      offer_b(5'd9, 1'b0 ^ 1'b1);
      nexte();
    end
    check("sat_fail", 32'(b_fail), 32'd3);
    check("sat_ffvec", 32'(b_ffvec), 32'd3);

    // Randomized traffic on both builds, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      if (ma.acc || !a_valid) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_vec   = 5'($urandom);
      end
      if (mb.acc || !b_valid) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_vec   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
      end
      a_y   = ($urandom_range(0, 4) != 0) ? exp_y(ma.vec) : 1'($urandom);
      b_y   = ($urandom_range(0, 4) != 0) ? exp_y(mb.vec) : 1'($urandom);
      a_clr = ($urandom_range(0, 60) == 0);
      b_clr = ($urandom_range(0, 60) == 0);
      nexte();
    end
    a_valid = 0; b_valid = 0; a_clr = 0; b_clr = 0;
    repeat (6) nexte();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/comb_resp_checker.md
Name: comb_resp_checker

Overview:
- Hardware response checker for single-output combinational functions of VEC_W inputs; it is the checking end of the vector-driving flow.
- Accepts input vectors over a valid/ready handshake and drives each one onto the function under check.
- Waits a programmable settle time, samples the function output and compares it against a parameterised truth table.
- Keeps pass/fail counts and captures the first failing vector; used in self-checking benches and on-chip BIST wrappers.

Parameters:
- VEC_W, 5, width of the input vector (function inputs a..e, a = bit 0).
- SETTLE_CYC, 2, cycles between applying a vector and sampling the output; 0 is legal.
- CNT_W, 16, width of the pass/fail counters.
- TRUTH, 32'h8000_0001, expected-output truth table, width 2**VEC_W; bit i is the expected y for vector i.

Ports:
- clk  in  1  clock; everything is clocked on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vec_valid  in  1  an input vector is offered.
- vec  in  VEC_W  the offered vector.
- vec_ready  out  1  the checker can accept a vector.
- vec_out  out  VEC_W  vector driven to the function under check.
- dut_y  in  1  output of the function under check.
- clear  in  1  synchronous clear of the counters and the first-fail capture.
- busy  out  1  a check is in flight.
- pass_cnt  out  CNT_W  number of matching samples.
- fail_cnt  out  CNT_W  number of mismatching samples.
- first_fail_vld  out  1  first_fail_vec holds a captured failure.
- first_fail_vec  out  VEC_W  first vector that mismatched since reset or clear.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, vec_ready=1, busy=0, vec_out=0.
  - pass_cnt=0, fail_cnt=0, first_fail_vld=0, first_fail_vec=0.
  - Settle counter=0.
  - Reset mid-check aborts the check with no count update.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - vec_ready=1, busy=0.
  - On vec_valid&vec_ready at edge k: latch vec into vec_out and load settle counter with SETTLE_CYC.
  - Next state is SETTLE if SETTLE_CYC>0, otherwise SAMPLE.
- SETTLE:
  - vec_ready=0, busy=1.
  - Counter decrements each cycle; when it reaches 1 the next state is SAMPLE.
- SAMPLE (one cycle):
  - vec_ready=0, busy=1.
  - At the edge leaving SAMPLE, compare dut_y with TRUTH[vec_out].
  - Match: pass_cnt+1. Mismatch: fail_cnt+1; if first_fail_vld=0, set first_fail_vld=1 and first_fail_vec=vec_out.
  - Next state is IDLE.
- Latency:
  - Vector accepted at edge k; the sample is taken from dut_y in the cycle before edge k+SETTLE_CYC+1.
  - Counters update at edge k+SETTLE_CYC+1; vec_ready=1 again in the following cycle.
  - Throughput is one vector per SETTLE_CYC+2 cycles.
- vec_out holds the last vector after a check, until the next acceptance.
- vec_valid while vec_ready=0 is ignored; no vector is lost silently, because the sender holds vec_valid until it sees ready.
- Counters saturate at 2**CNT_W-1 and do not wrap. A saturated counter does not block first-fail capture.
- clear:
  - Zeroes pass_cnt, fail_cnt, first_fail_vld and first_fail_vec at the next edge.
  - If clear coincides with the SAMPLE edge, clear wins and that result is discarded.
  - clear does not abort an in-flight check; that check completes and counts normally unless clear hits its SAMPLE edge.
  - clear does not change state or vec_out.
- TRUTH indexing is TRUTH[vec_out] with vec_out treated as unsigned.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/SETTLE/SAMPLE).
  - Default TRUTH constant.
  - Default VEC_W/CNT_W constants.
- Sub-module sat_counter (parameter W; inputs inc and clr; output cnt), instantiated twice for pass_cnt and fail_cnt.

Test Plan:
- Reset, then vector 5'b00000 with dut_y=1, SETTLE_CYC=2 → accepted at edge k; pass_cnt=1 at edge k+3; vec_ready back high one cycle later; fail_cnt=0.
- Vector 5'b00001 with dut_y=1 (TRUTH bit1=0) → fail_cnt=1, first_fail_vld=1, first_fail_vec=5'b00001. A following failing vector 5'b00010 → fail_cnt=2, first_fail_vec unchanged.
- vec_valid held high with back-to-back vectors 0 and 31 (dut_y=1) → second vector accepted exactly 4 cycles after the first; pass_cnt=2; no vector dropped.
- SETTLE_CYC=0 build, vector 5'b11111 with dut_y=1 → pass_cnt=1 one edge after acceptance.
- clear asserted on the SAMPLE edge of a failing vector → fail_cnt=0 and first_fail_vld=0 after the edge; FSM returns to IDLE.
- rst_n pulsed low during SETTLE → all outputs at reset values immediately (asynchronous); next accepted vector checks normally. Force CNT_W=2 and run 5 passes → pass_cnt stays at 3.
